mem_phase_sequencer: RTL

//  Requester-side sequencer for the shared time-multiplexed instruction/data memory (bram).

---
 rtl/mem_phase_sequencer_pkg.sv | 5 +
 rtl/mem_phase_ring.sv | 21 ++
 rtl/mem_phase_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/mem_phase_sequencer_pkg.sv
// mem_phase_sequencer_pkg: phase encodings and shared constants for the memory phase sequencer
package mem_phase_sequencer_pkg;
   typedef enum logic [2:0] {PH_IDLE, PH_I1, PH_I2, PH_D, PH_G} phase_t;
   localparam int MIN_DADDR = 2;
endpackage

// File: rtl/mem_phase_ring.sv
// mem_phase_ring: IDLE/I1/I2/D/G frame FSM; nxt is the one-hot {I1,I2,D,G} phase entered at the next edge
module mem_phase_ring
   import mem_phase_sequencer_pkg::*;
(
   input  logic       idclk,
   input  logic       rst,
   input  logic       en,
   output phase_t     ph,
   output logic [3:0] nxt
);
   phase_t ph_n;
   always_comb begin
      ph_n = ph == PH_I1 ? PH_I2 :
             ph == PH_I2 ? PH_D  :
             ph == PH_D  ? PH_G  :
             en          ? PH_I1 : PH_IDLE;
      nxt  = {ph_n == PH_I1, ph_n == PH_I2, ph_n == PH_D, ph_n == PH_G};
   end
   always_ff @(posedge idclk)
      ph <= rst ? PH_IDLE : ph_n;
endmodule

// File: rtl/mem_phase_sequencer.sv
// mem_phase_sequencer: drives 4-cycle I1/I2/D/G frames on the shared bram and returns
// fetch/read/write responses to core 1, core 2 and the data client as one-cycle pulses.
module mem_phase_sequencer
   import mem_phase_sequencer_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int INSN      = 19,
   parameter int IADDR     = 10,
   parameter int DADDR     = 4
)(
   input  logic                 idclk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 c1_req,
   input  logic [IADDR:0]       c1_addr,
   input  logic                 c2_req,
   input  logic [IADDR:0]       c2_addr,
   input  logic                 d_rd_req,
   input  logic [DADDR:0]       d_raddr,
   input  logic                 d_wr_req,
   input  logic [DADDR:0]       d_waddr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 i1re,
   output logic                 i2re,
   output logic                 dre,
   output logic                 gwe,
   output logic [IADDR:0]       i1addr,
   output logic [IADDR:0]       i2addr,
   output logic [DADDR:0]       draddr,
   output logic [DADDR:0]       dwaddr,
   output logic [WORD_SIZE-1:0] din,
   output logic                 dwe,
   input  logic [INSN:0]        i1out,
   input  logic [INSN:0]        i2out,
   input  logic [WORD_SIZE-1:0] dout,
   output logic [INSN:0]        c1_insn,
   output logic [INSN:0]        c2_insn,
   output logic                 c1_valid,
   output logic                 c2_valid,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_rvalid,
   output logic                 d_wack,
   output logic                 d_err
);
   phase_t     ph;
   logic [3:0] nxt;
   logic       f_c1, f_c2, f_rd, f_wr, w_ok, r_ok, rd_done;
   mem_phase_ring u_ring (.idclk(idclk), .rst(rst), .en(en), .ph(ph), .nxt(nxt));
   // addresses 0 and 1 have no backing storage
   always_comb begin
      w_ok    = dwaddr >= (DADDR+1)'(MIN_DADDR);
      r_ok    = draddr >= (DADDR+1)'(MIN_DADDR);
      rd_done = ph == PH_G && f_rd;
   end
   always_ff @(posedge idclk) begin
      if (rst) begin
         {i1re, i2re, dre, gwe} <= '0;
         {f_c1, f_c2, f_rd, f_wr} <= '0;
         {dwe, c1_valid, c2_valid, d_rvalid, d_wack, d_err} <= '0;
         i1addr  <= '0;
         i2addr  <= '0;
         draddr  <= '0;
         dwaddr  <= '0;
         din     <= '0;
         c1_insn <= '0;
         c2_insn <= '0;
         d_rdata <= '0;
      end else begin
         {i1re, i2re, dre, gwe} <= nxt;
         if (nxt[3]) begin
            {f_c1, f_c2, f_rd, f_wr} <= {c1_req, c2_req, d_rd_req, d_wr_req};
            i1addr <= c1_addr;
            i2addr <= c2_addr;
            draddr <= d_raddr;
            dwaddr <= d_waddr;
            din    <= d_wdata;
         end
         dwe      <= (nxt[1] | nxt[0]) & f_wr & w_ok;
         c1_valid <= ph == PH_I2 && f_c1;
         c2_valid <= ph == PH_D && f_c2;
         d_rvalid <= rd_done;
         d_wack   <= ph == PH_D && f_wr && w_ok;
         d_err    <= (ph == PH_D && f_wr && !w_ok) || (rd_done && !r_ok);
         if (ph == PH_I2 && f_c1) c1_insn <= i1out;
         if (ph == PH_D && f_c2) c2_insn <= i2out;
         if (rd_done) d_rdata <= r_ok ? dout : '0;
      end
   end
endmodule
